// File: rtl/condicionador_entrada.sv
// Button input conditioner: two-flop synchroniser, confirmation-state debouncer,
// and a one-cycle pulse per confirmed press for the downstream counting FSM.
module condicionador_entrada #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          POLARIDADE      = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    output logic nivel_estavel,
    output logic entrada_pulso,
    output logic pressionado_raw
);

    typedef enum logic [1:0] {
        StBaixo         = 2'b00,
        StConfirmaAlto  = 2'b01,
        StAlto          = 2'b10,
        StConfirmaBaixo = 2'b11
    } estado_t;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntUm  = CNT_W'(1);

    logic [1:0]       sinc_q;
    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nivel_q, nivel_d;
    logic             pulso_q, pulso_d;
    logic             botao_s;

    assign botao_s = sinc_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sinc_q   <= 2'b00;
            estado_q <= StBaixo;
            cnt_q    <= '0;
            nivel_q  <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            // Polarity fixed before the first flop; nothing between the two flops.
            sinc_q   <= {sinc_q[0], botao ^ POLARIDADE};
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nivel_q  <= nivel_d;
            pulso_q  <= pulso_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            StBaixo: begin
                if (botao_s) begin
                    estado_d = StConfirmaAlto;
                    cnt_d    = CntUm;
                end else begin
                    cnt_d = '0;
                end
            end
            StConfirmaAlto: begin
                if (!botao_s) begin
                    estado_d = StBaixo;
                    cnt_d    = '0;
                end else if (cnt_q == CntMax) begin
                    estado_d = StAlto;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntUm;
                end
            end
            StAlto: begin
                if (!botao_s) begin
                    estado_d = StConfirmaBaixo;
                    cnt_d    = CntUm;
                end else begin
                    cnt_d = '0;
                end
            end
            StConfirmaBaixo: begin
                if (botao_s) begin
                    estado_d = StAlto;
                    cnt_d    = '0;
                end else if (cnt_q == CntMax) begin
                    estado_d = StBaixo;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntUm;
                end
            end
            default: begin
                estado_d = StBaixo;
                cnt_d    = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state change.
    always_comb begin
        nivel_d = (estado_d == StAlto) || (estado_d == StConfirmaBaixo);
        pulso_d = (estado_q == StConfirmaAlto) && (estado_d == StAlto);
    end

    assign nivel_estavel   = nivel_q;
    assign entrada_pulso   = pulso_q;
    assign pressionado_raw = sinc_q[1];

endmodule
